cdb_result_buffer: RTL and testbench
====================================

// Module: cdb_result_buffer
// PURPOSE
//  Per-functional-unit result FIFO sitting directly upstream of the common data bus arbiter.
//  Accepts {tag,value} results from a functional unit (ALU/mul/div/ls/branch), raises the CDB request
//  while non-empty and holds the head entry stable until it wins arbitration.
//  Local grant is inferred from higher_prio_request (fixed priority ALU>mul>div>ls>branch); pops on win.
//  Also counts consecutive lost-arbitration cycles and flags starvation.
// PARAMETERS
//  DEPTH        4    FIFO entries; power of two, >=2
//  WIDTH        40   result width; [39:32] ROB/RS tag, [31:0] value
//  STARVE_LIMIT 16   consecutive denied-request cycles before starved asserts; >=1
// PORTS
//  clk                 in   1      clock, all state on rising edge
//  rst_n               in   1      asynchronous, active-low reset
//  flush               in   1      synchronous squash (mispredict); empties buffer
//  fu_valid            in   1      functional unit presents a result this cycle
//  fu_result           in   WIDTH  result payload {tag,value}
//  fu_ready            out  1      buffer can accept; push = fu_valid & fu_ready
//  higher_prio_request in   1      OR of all higher-priority units' CDB requests
//  cdb_request         out  1      to arbiter: head entry wants the bus
//  cdb_out             out  WIDTH  to arbiter: head entry payload
//  count               out  $clog2(DEPTH)+1  occupancy
//  starved             out  1      denied for >= STARVE_LIMIT consecutive cycles
// BEHAVIOUR
//  - Reset (rst_n=0, async): rd_ptr=wr_ptr=0, count=0, stall_cnt=0; cdb_request=0, cdb_out=0, fu_ready=1, starved=0.
//  - Storage: circular array, pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH (distinguishes full/empty).
//  - cdb_request = (count!=0) (combinational from state); cdb_out = mem[rd_ptr] when non-empty, else 0.
//  - grant = cdb_request & ~higher_prio_request (same cycle arbiter samples); pop on the edge where grant=1.
//  - Arbiter registers the bus, so the popped entry appears on cdb one cycle after pop; head must not change before pop.
//  - fu_ready = (count<DEPTH); no full-with-pop pass-through: push refused when full even if popping.
//  - Push and pop same edge: both pointers advance, count unchanged; push into empty with no pop -> request next cycle.
//  - Minimum latency fu_valid -> cdb_request: 1 cycle (base build).
//  - fu_valid while full: result dropped by buffer; FU must hold it (fu_ready=0 is the backpressure).
//  - flush=1: next edge rd_ptr=wr_ptr=0, count=0, stall_cnt=0; concurrent push/pop ignored; request deasserts next cycle.
//  - Starvation: stall_cnt increments each cycle cdb_request & higher_prio_request, saturates at STARVE_LIMIT;
//    clears on grant, on empty, on flush. starved = (stall_cnt==STARVE_LIMIT), registered-state output.
//  - Reset mid-operation: all entries discarded instantly; no partial pop; outputs at reset values while rst_n=0.
// CONFIGURATION
//  CDB_BYPASS_EN defined: when count==0 and fu_valid, fu_result drives cdb_out and cdb_request combinationally
//    same cycle; if granted, entry is not written (no push); if denied, it is pushed normally.
//    Latency fu_valid -> request becomes 0 cycles when empty. fu_ready unchanged.
//  CDB_BYPASS_EN undefined: every result is written first; request only from stored entries (1-cycle minimum).
// TESTING
//  1 Reset: rst_n=0 mid-burst with count=3 -> count=0, cdb_request=0, cdb_out=0, fu_ready=1, starved=0 immediately.
//  2 Single result: push 0x05_0000002A, higher_prio=0 -> next cycle cdb_request=1, cdb_out=0x050000002A,
//    popped that edge, count 1->0.
//  3 Fill/backpressure: DEPTH=4, higher_prio=1, push 5 results -> fu_ready=0 after 4th, 5th not stored,
//    then release -> 4 entries drain in order, one per cycle, pointers wrap correctly.
//  4 Simultaneous push/pop at count=2 -> count stays 2, FIFO order preserved across 8 cycles of streaming.
//  5 Starvation: count=1, higher_prio=1 for 20 cycles -> starved=1 from cycle 16, drops the cycle after grant.
//  6 Flush with count=3 and concurrent fu_valid -> count=0 next cycle, cdb_request=0, new result not stored;
//    with CDB_BYPASS_EN: empty buffer + fu_valid + higher_prio=0 -> request same cycle, count stays 0.

Source files
------------

// File: rtl/cdb_result_buffer.sv
// cdb_result_buffer: per-functional-unit result FIFO feeding the common data bus arbiter.
// Holds {tag,value} results, requests the CDB while non-empty, keeps the head stable until
// it wins fixed-priority arbitration (grant inferred from higher_prio_request), and flags
// starvation after STARVE_LIMIT consecutive denied cycles.
// Optional build macro: CDB_BYPASS_EN -- an empty buffer forwards fu_result to the CDB in the
// same cycle; a granted bypassed result is never written into the FIFO.
module cdb_result_buffer #(
   parameter int DEPTH        = 4,
   parameter int WIDTH        = 40,
   parameter int STARVE_LIMIT = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     fu_valid,
   input  logic [WIDTH-1:0]         fu_result,
   output logic                     fu_ready,
   input  logic                     higher_prio_request,
   output logic                     cdb_request,
   output logic [WIDTH-1:0]         cdb_out,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     starved
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [SW-1:0]    stall_cnt;

   logic not_empty;
   logic bypass;
   logic grant;
   logic push;
   logic pop;

   // Request/grant decode, head presentation and push/pop qualification
   always_comb begin
      not_empty = (count != '0);
      fu_ready  = (count < DEPTH_C);
`ifdef CDB_BYPASS_EN
      // Empty buffer forwards the incoming result directly; squashed results never reach the bus
      bypass    = rst_n & ~not_empty & fu_valid & ~flush;
`else
      bypass    = 1'b0;
`endif
      cdb_request = not_empty | bypass;
      if (not_empty)
         cdb_out = mem[rd_ptr];
      else if (bypass)
         cdb_out = fu_result;
      else
         cdb_out = '0;
      grant   = cdb_request & ~higher_prio_request;
      pop     = grant & not_empty & ~flush;
      // A bypassed result that wins the bus is consumed without being stored
      push    = fu_valid & fu_ready & ~flush & ~(grant & bypass);
      starved = (stall_cnt == STARVE_C);
   end

   // Result storage; contents are only observable through count-qualified reads, so no reset
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= fu_result;
   end

   // Pointers and occupancy; flush squashes everything including a concurrent push or pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Consecutive denied-request counter, saturating at the starvation limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (flush || grant || !cdb_request) begin
         stall_cnt <= '0;
      end else if (stall_cnt != STARVE_C) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_cdb_result_buffer.sv
// Testbench for cdb_result_buffer: constant vector table, hand-written corner sequences
// (reset mid-burst, flush, starvation, optional bypass) and a randomized run against a
// queue-based reference model.
module tb_cdb_result_buffer;

   localparam int DEPTH = 4;
   localparam int WIDTH = 40;
   localparam int LIMIT = 16;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             fu_valid;
   logic [WIDTH-1:0] fu_result;
   logic             fu_ready;
   logic             higher_prio_request;
   logic             cdb_request;
   logic [WIDTH-1:0] cdb_out;
   logic [2:0]       count;
   logic             starved;

   int checks;
   int errors;

   cdb_result_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .flush               (flush),
      .fu_valid            (fu_valid),
      .fu_result           (fu_result),
      .fu_ready            (fu_ready),
      .higher_prio_request (higher_prio_request),
      .cdb_request         (cdb_request),
      .cdb_out             (cdb_out),
      .count               (count),
      .starved             (starved)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic             fv;
      logic [WIDTH-1:0] res;
      logic             hp;
      logic             req;
      logic [WIDTH-1:0] out;
      logic             rdy;
      logic [2:0]       cnt;
   } vec_t;

   vec_t tbl [24];

   // Reference model state: plain queue of pending results plus a denied-cycle tally
   logic [WIDTH-1:0] q [$];
   int               stall;

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic fl, input logic fv, input logic [WIDTH-1:0] res, input logic hp);
      flush               = fl;
      fu_valid            = fv;
      fu_result           = res;
      higher_prio_request = hp;
      #1;
   endtask

   // Compare every output against the model for the inputs currently applied
   task automatic check_model(input string tag);
      logic             e_req;
      logic [WIDTH-1:0] e_out;
      logic             byp;
      byp = 1'b0;
`ifdef CDB_BYPASS_EN
      byp = (q.size() == 0) && fu_valid && !flush;
`endif
      e_req = (q.size() != 0) || byp;
      e_out = (q.size() != 0) ? q[0] : (byp ? fu_result : '0);
      check({tag, ".req"},     WIDTH'(cdb_request), WIDTH'(e_req));
      check({tag, ".out"},     cdb_out, e_out);
      check({tag, ".ready"},   WIDTH'(fu_ready), WIDTH'(q.size() < DEPTH));
      check({tag, ".count"},   WIDTH'(count), WIDTH'(q.size()));
      check({tag, ".starved"}, WIDTH'(starved), WIDTH'(stall == LIMIT));
   endtask

   // Advance the model by one clock edge using the applied inputs
   task automatic model_edge();
      logic req;
      logic grant;
      logic byp;
      int   sz;
      byp = 1'b0;
`ifdef CDB_BYPASS_EN
      byp = (q.size() == 0) && fu_valid && !flush;
`endif
      sz    = q.size();
      req   = (sz != 0) || byp;
      grant = req && !higher_prio_request;
      if (flush) begin
         q.delete();
         stall = 0;
      end else begin
         if (grant && sz != 0)
            void'(q.pop_front());
         if (fu_valid && sz < DEPTH && !(grant && byp))
            q.push_back(fu_result);
         if (grant || !req)
            stall = 0;
         else if (stall < LIMIT)
            stall++;
      end
   endtask

   task automatic model_cycle(input string tag);
      check_model(tag);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, '0, 1'b0);
      q.delete();
      stall = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      q.delete();
      stall = 0;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, '0, 1'b0);
      #3;
      check("rst.count",   WIDTH'(count), '0);
      check("rst.req",     WIDTH'(cdb_request), '0);
      check("rst.out",     cdb_out, '0);
      check("rst.ready",   WIDTH'(fu_ready), WIDTH'(1'b1));
      check("rst.starved", WIDTH'(starved), '0);
      do_reset();

`ifndef CDB_BYPASS_EN
      // Single result, fill/backpressure/drain with wrap, then push+pop streaming at count=2
      tbl[0]  = '{1'b1, 40'h05_0000002A, 1'b0, 1'b0, 40'h0,            1'b1, 3'd0};
      tbl[1]  = '{1'b0, 40'h0,           1'b0, 1'b1, 40'h05_0000002A,  1'b1, 3'd1};
      tbl[2]  = '{1'b0, 40'h0,           1'b0, 1'b0, 40'h0,            1'b1, 3'd0};
      tbl[3]  = '{1'b1, 40'hA1_00000001, 1'b1, 1'b0, 40'h0,            1'b1, 3'd0};
      tbl[4]  = '{1'b1, 40'hA2_00000002, 1'b1, 1'b1, 40'hA1_00000001,  1'b1, 3'd1};
      tbl[5]  = '{1'b1, 40'hA3_00000003, 1'b1, 1'b1, 40'hA1_00000001,  1'b1, 3'd2};
      tbl[6]  = '{1'b1, 40'hA4_00000004, 1'b1, 1'b1, 40'hA1_00000001,  1'b1, 3'd3};
      tbl[7]  = '{1'b1, 40'hA5_00000005, 1'b1, 1'b1, 40'hA1_00000001,  1'b0, 3'd4};
      tbl[8]  = '{1'b0, 40'h0,           1'b0, 1'b1, 40'hA1_00000001,  1'b0, 3'd4};
      tbl[9]  = '{1'b0, 40'h0,           1'b0, 1'b1, 40'hA2_00000002,  1'b1, 3'd3};
      tbl[10] = '{1'b0, 40'h0,           1'b0, 1'b1, 40'hA3_00000003,  1'b1, 3'd2};
      tbl[11] = '{1'b0, 40'h0,           1'b0, 1'b1, 40'hA4_00000004,  1'b1, 3'd1};
      tbl[12] = '{1'b0, 40'h0,           1'b0, 1'b0, 40'h0,            1'b1, 3'd0};
      tbl[13] = '{1'b1, 40'hB1_00000011, 1'b1, 1'b0, 40'h0,            1'b1, 3'd0};
      tbl[14] = '{1'b1, 40'hB2_00000012, 1'b1, 1'b1, 40'hB1_00000011,  1'b1, 3'd1};
      tbl[15] = '{1'b1, 40'hB3_00000013, 1'b0, 1'b1, 40'hB1_00000011,  1'b1, 3'd2};
      tbl[16] = '{1'b1, 40'hB4_00000014, 1'b0, 1'b1, 40'hB2_00000012,  1'b1, 3'd2};
      tbl[17] = '{1'b1, 40'hB5_00000015, 1'b0, 1'b1, 40'hB3_00000013,  1'b1, 3'd2};
      tbl[18] = '{1'b1, 40'hB6_00000016, 1'b0, 1'b1, 40'hB4_00000014,  1'b1, 3'd2};
      tbl[19] = '{1'b1, 40'hB7_00000017, 1'b0, 1'b1, 40'hB5_00000015,  1'b1, 3'd2};
      tbl[20] = '{1'b1, 40'hB8_00000018, 1'b0, 1'b1, 40'hB6_00000016,  1'b1, 3'd2};
      tbl[21] = '{1'b0, 40'h0,           1'b0, 1'b1, 40'hB7_00000017,  1'b1, 3'd2};
      tbl[22] = '{1'b0, 40'h0,           1'b0, 1'b1, 40'hB8_00000018,  1'b1, 3'd1};
      tbl[23] = '{1'b0, 40'h0,           1'b0, 1'b0, 40'h0,            1'b1, 3'd0};
      for (int i = 0; i < 24; i++) begin
         drive(1'b0, tbl[i].fv, tbl[i].res, tbl[i].hp);
         check($sformatf("vec%0d.req", i),   WIDTH'(cdb_request), WIDTH'(tbl[i].req));
         check($sformatf("vec%0d.out", i),   cdb_out, tbl[i].out);
         check($sformatf("vec%0d.ready", i), WIDTH'(fu_ready), WIDTH'(tbl[i].rdy));
         check($sformatf("vec%0d.count", i), WIDTH'(count), WIDTH'(tbl[i].cnt));
         tick();
      end
`endif

      // Starvation: one entry held off for 20 cycles, then granted
      do_reset();
      drive(1'b0, 1'b1, 40'h33_000000C3, 1'b1);
      tick();
      for (int k = 1; k <= 20; k++) begin
         drive(1'b0, 1'b0, '0, 1'b1);
         check($sformatf("starve%0d", k), WIDTH'(starved), WIDTH'(k > LIMIT));
         tick();
      end
      drive(1'b0, 1'b0, '0, 1'b0);
      check("starve.grant_cycle", WIDTH'(starved), WIDTH'(1'b1));
      check("starve.head", cdb_out, 40'h33_000000C3);
      tick();
      check("starve.after_grant", WIDTH'(starved), '0);
      check("starve.count", WIDTH'(count), '0);

      // Flush with count=3 and a concurrent new result
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, WIDTH'(40'h44_00000000 + k), 1'b1);
         tick();
      end
      check("flush.pre_count", WIDTH'(count), WIDTH'(3));
      drive(1'b1, 1'b1, 40'h55_00000055, 1'b0);
      tick();
      drive(1'b0, 1'b0, '0, 1'b0);
      check("flush.count", WIDTH'(count), '0);
      check("flush.req", WIDTH'(cdb_request), '0);
      check("flush.out", cdb_out, '0);
      tick();
      check("flush.not_stored", WIDTH'(count), '0);

      // Asynchronous reset mid-burst with count=3 and starvation already flagged
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, WIDTH'(40'h66_00000000 + k), 1'b1);
         tick();
      end
      drive(1'b0, 1'b0, '0, 1'b1);
      repeat (18) tick();
      check("rstmid.pre_starved", WIDTH'(starved), WIDTH'(1'b1));
      check("rstmid.pre_count", WIDTH'(count), WIDTH'(3));
      drive(1'b0, 1'b1, 40'h77_00000077, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rstmid.count",   WIDTH'(count), '0);
      check("rstmid.req",     WIDTH'(cdb_request), '0);
      check("rstmid.out",     cdb_out, '0);
      check("rstmid.ready",   WIDTH'(fu_ready), WIDTH'(1'b1));
      check("rstmid.starved", WIDTH'(starved), '0);
      do_reset();

`ifdef CDB_BYPASS_EN
      // Bypass: empty buffer, result presented and granted in the same cycle, never stored
      drive(1'b0, 1'b1, 40'h88_00000088, 1'b0);
      check("byp.req", WIDTH'(cdb_request), WIDTH'(1'b1));
      check("byp.out", cdb_out, 40'h88_00000088);
      tick();
      drive(1'b0, 1'b0, '0, 1'b0);
      check("byp.count", WIDTH'(count), '0);
      check("byp.req_after", WIDTH'(cdb_request), '0);
      tick();
`endif

      // Randomized traffic checked against the queue model
      do_reset();
      begin
         int bias;
         bias = 0;
         for (int c = 0; c < 3000; c++) begin
            if (c % 48 == 0)
               bias = int'($urandom_range(0, 4));
            drive(($urandom_range(0, 63) == 0),
                  1'($urandom_range(0, 1)),
                  {8'($urandom), 32'($urandom)},
                  (int'($urandom_range(0, 3)) < bias));
            model_cycle("rand");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
